branch_predictor: RTL and testbench

//  Fetch-side counterpart of the EX-stage branch resolver: predicts direction and target for pc_IF

---
 rtl/bpu_pkg.sv | 31 +++
 rtl/bpu_table.sv | 74 +++++++
 rtl/branch_predictor.sv | 80 ++++++++
 tb/tb_branch_predictor.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/bpu_pkg.sv
`default_nettype none
// ============================================================================
// Module  : bpu_pkg
// Brief   : Shared counter encodings, default geometry and counter update.
// Revision: 1.0
// ============================================================================
package bpu_pkg;

    localparam int DEF_INDEX_BITS = 6;
    localparam int DEF_TAG_BITS   = 8;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr_t;

    function automatic ctr_t sat_update(input ctr_t ctr, input logic taken);
        ctr_t nxt;
        nxt = ctr;
        if (taken) begin
            if (ctr != ST) nxt = ctr_t'(ctr + 2'b01);
        end else begin
            if (ctr != SNT) nxt = ctr_t'(ctr - 2'b01);
        end
        return nxt;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bpu_table.sv
`default_nettype none
// ============================================================================
// Module  : bpu_table
// Brief   : Direct-mapped BTB + 2-bit counters; async IF read, sync EX write.
// Revision: 1.0
// ============================================================================
module bpu_table
    import bpu_pkg::*;
#(
    parameter int INDEX_BITS = DEF_INDEX_BITS,
    parameter int TAG_BITS   = DEF_TAG_BITS
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] rd_pc,
    output logic        rd_hit,
    output ctr_t        rd_ctr,
    output logic [31:0] rd_target,
    input  logic [31:0] wr_pc,
    input  logic        train_en,
    input  logic        train_taken,
    input  logic [31:0] train_target,
    input  logic        inval_en
);

    localparam int DEPTH = 2 ** INDEX_BITS;

    logic                  valid  [DEPTH];
    logic [TAG_BITS-1:0]   tag    [DEPTH];
    logic [31:0]           target [DEPTH];
    ctr_t                  ctr    [DEPTH];

    logic [INDEX_BITS-1:0] rd_idx;
    logic [TAG_BITS-1:0]   rd_tag;
    logic [INDEX_BITS-1:0] wr_idx;
    logic [TAG_BITS-1:0]   wr_tag;
    logic                  wr_hit;

    assign rd_idx = rd_pc[INDEX_BITS+1:2];
    assign rd_tag = rd_pc[INDEX_BITS+TAG_BITS+1:INDEX_BITS+2];
    assign wr_idx = wr_pc[INDEX_BITS+1:2];
    assign wr_tag = wr_pc[INDEX_BITS+TAG_BITS+1:INDEX_BITS+2];

    // Read sees pre-update contents; a same-cycle write lands at the edge.
    assign rd_hit    = valid[rd_idx] && (tag[rd_idx] == rd_tag);
    assign rd_ctr    = ctr[rd_idx];
    assign rd_target = target[rd_idx];
    assign wr_hit    = valid[wr_idx] && (tag[wr_idx] == wr_tag);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                valid[i]  <= 1'b0;
                tag[i]    <= '0;
                target[i] <= '0;
                ctr[i]    <= WNT;
            end
        end else if (train_en) begin
            if (wr_hit) begin
                ctr[wr_idx] <= sat_update(ctr[wr_idx], train_taken);
                if (train_taken) target[wr_idx] <= train_target;
            end else if (train_taken) begin
                valid[wr_idx]  <= 1'b1;
                tag[wr_idx]    <= wr_tag;
                target[wr_idx] <= train_target;
                ctr[wr_idx]    <= WT;
            end
        end else if (inval_en) begin
            valid[wr_idx] <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/branch_predictor.sv
`default_nettype none
// ============================================================================
// Module  : branch_predictor
// Brief   : IF-side BTB prediction, EX-side training, mispredict and stats.
// Revision: 1.0
// ============================================================================
module branch_predictor
    import bpu_pkg::*;
#(
    parameter int INDEX_BITS = DEF_INDEX_BITS,
    parameter int TAG_BITS   = DEF_TAG_BITS
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc_IF,
    output logic        predict_taken_IF,
    output logic [31:0] predicted_target_IF,
    input  logic        Branch_EX,
    input  logic        taken_EX,
    input  logic [31:0] pc_EX,
    input  logic [31:0] target_EX,
    input  logic        predicted_EX,
    input  logic [31:0] predicted_target_EX,
    input  logic        hold,
    output logic        mispredict,
    output logic [31:0] recovery_pc,
    output logic [31:0] branch_count,
    output logic [31:0] mispredict_count
);

    logic        ev;
    logic        rd_hit;
    ctr_t        rd_ctr;
    logic [31:0] branch_cnt;
    logic [31:0] mispredict_cnt;

    assign ev = !hold && !reset;

    bpu_table #(
        .INDEX_BITS (INDEX_BITS),
        .TAG_BITS   (TAG_BITS)
    ) u_table (
        .clk          (clk),
        .reset        (reset),
        .rd_pc        (pc_IF),
        .rd_hit       (rd_hit),
        .rd_ctr       (rd_ctr),
        .rd_target    (predicted_target_IF),
        .wr_pc        (pc_EX),
        .train_en     (ev && Branch_EX),
        .train_taken  (taken_EX),
        .train_target (target_EX),
        .inval_en     (ev && !Branch_EX && predicted_EX)
    );

    assign predict_taken_IF = !reset && rd_hit && rd_ctr[1];

    // Wrong direction, wrong target, or a non-branch that fetch steered away.
    assign mispredict = ev && ((Branch_EX && (taken_EX != predicted_EX))
                            || (Branch_EX && taken_EX && predicted_EX
                                && (predicted_target_EX != target_EX))
                            || (!Branch_EX && predicted_EX));

    assign recovery_pc = (Branch_EX && taken_EX) ? target_EX : pc_EX + 32'd4;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            branch_cnt     <= '0;
            mispredict_cnt <= '0;
        end else begin
            if (ev && Branch_EX) branch_cnt <= branch_cnt + 32'd1;
            if (mispredict)      mispredict_cnt <= mispredict_cnt + 32'd1;
        end
    end

    assign branch_count     = branch_cnt;
    assign mispredict_count = mispredict_cnt;

endmodule
`default_nettype wire

// File: tb/tb_branch_predictor.sv
`default_nettype none
// ============================================================================
// Module  : tb_branch_predictor
// Brief   : Directed self-checking bench for branch_predictor.
// Revision: 1.0
// ============================================================================
module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc_IF;
    logic        predict_taken_IF;
    logic [31:0] predicted_target_IF;
    logic        Branch_EX;
    logic        taken_EX;
    logic [31:0] pc_EX;
    logic [31:0] target_EX;
    logic        predicted_EX;
    logic [31:0] predicted_target_EX;
    logic        hold;
    logic        mispredict;
    logic [31:0] recovery_pc;
    logic [31:0] branch_count;
    logic [31:0] mispredict_count;

    int total = 0;
    int bad   = 0;

    branch_predictor dut (
        .clk                 (clk),
        .reset               (reset),
        .pc_IF               (pc_IF),
        .predict_taken_IF    (predict_taken_IF),
        .predicted_target_IF (predicted_target_IF),
        .Branch_EX           (Branch_EX),
        .taken_EX            (taken_EX),
        .pc_EX               (pc_EX),
        .target_EX           (target_EX),
        .predicted_EX        (predicted_EX),
        .predicted_target_EX (predicted_target_EX),
        .hold                (hold),
        .mispredict          (mispredict),
        .recovery_pc         (recovery_pc),
        .branch_count        (branch_count),
        .mispredict_count    (mispredict_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic ex(input logic br, input logic tk, input logic [31:0] pc,
                      input logic [31:0] tgt, input logic pred, input logic [31:0] ptgt);
        Branch_EX           = br;
        taken_EX            = tk;
        pc_EX               = pc;
        target_EX           = tgt;
        predicted_EX        = pred;
        predicted_target_EX = ptgt;
    endtask

    // Advance to the next falling edge (past one rising edge) with EX idle.
    task automatic next_idle();
        @(negedge clk);
        ex(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        hold  = 1'b0;
        pc_IF = 32'h100;
        ex(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
        #1;
        chk("rst_pred", {31'd0, predict_taken_IF}, 32'd0);
        chk("rst_misp", {31'd0, mispredict}, 32'd0);
        chk("rst_bcnt", branch_count, 32'd0);
        chk("rst_mcnt", mispredict_count, 32'd0);

        // 1: first taken branch allocates
        @(negedge clk);
        reset = 1'b0;
        ex(1'b1, 1'b1, 32'h100, 32'h200, 1'b0, 32'h0);
        #1;
        chk("t1_misp", {31'd0, mispredict}, 32'd1);
        chk("t1_rpc", recovery_pc, 32'h200);
        chk("t1_pred_same_cycle", {31'd0, predict_taken_IF}, 32'd0);
        next_idle();
        chk("t1_pred", {31'd0, predict_taken_IF}, 32'd1);
        chk("t1_tgt", predicted_target_IF, 32'h200);

        // 2: saturate up, then walk down to weakly-not-taken
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            ex(1'b1, 1'b1, 32'h100, 32'h200, 1'b1, 32'h200);
            #1;
            chk("t2_up_misp", {31'd0, mispredict}, 32'd0);
        end
        @(negedge clk);
        ex(1'b1, 1'b0, 32'h100, 32'h200, 1'b1, 32'h200);
        #1;
        chk("t2_nt1_misp", {31'd0, mispredict}, 32'd1);
        chk("t2_nt1_rpc", recovery_pc, 32'h104);
        @(negedge clk);
        ex(1'b1, 1'b0, 32'h100, 32'h200, 1'b1, 32'h200);
        #1;
        chk("t2_nt2_pred", {31'd0, predict_taken_IF}, 32'd1);
        chk("t2_nt2_misp", {31'd0, mispredict}, 32'd1);
        next_idle();
        chk("t2_pred_off", {31'd0, predict_taken_IF}, 32'd0);
        chk("t2_bcnt", branch_count, 32'd6);
        chk("t2_mcnt", mispredict_count, 32'd3);

        // 3: retrain to WT, then invalidate via aliased non-branch
        @(negedge clk);
        ex(1'b1, 1'b1, 32'h100, 32'h200, 1'b0, 32'h0);
        #1;
        chk("t3_retrain_misp", {31'd0, mispredict}, 32'd1);
        next_idle();
        chk("t3_pred_on", {31'd0, predict_taken_IF}, 32'd1);
        @(negedge clk);
        ex(1'b0, 1'b0, 32'h10100, 32'h0, 1'b1, 32'h200);
        #1;
        chk("t3_alias_misp", {31'd0, mispredict}, 32'd1);
        chk("t3_alias_rpc", recovery_pc, 32'h10104);
        next_idle();
        chk("t3_inval_pred", {31'd0, predict_taken_IF}, 32'd0);
        chk("t3_bcnt", branch_count, 32'd7);
        chk("t3_mcnt", mispredict_count, 32'd5);

        // 4: target mismatch on a predicted-taken branch
        @(negedge clk);
        ex(1'b1, 1'b1, 32'h100, 32'h300, 1'b1, 32'h200);
        #1;
        chk("t4_misp", {31'd0, mispredict}, 32'd1);
        chk("t4_rpc", recovery_pc, 32'h300);
        next_idle();
        chk("t4_pred", {31'd0, predict_taken_IF}, 32'd1);
        chk("t4_tgt", predicted_target_IF, 32'h300);

        // 5: hold freezes everything, then mid-stream reset
        @(negedge clk);
        hold = 1'b1;
        ex(1'b1, 1'b1, 32'h100, 32'h400, 1'b0, 32'h0);
        #1;
        chk("t5_hold_misp", {31'd0, mispredict}, 32'd0);
        chk("t5_hold_lookup", {31'd0, predict_taken_IF}, 32'd1);
        @(negedge clk);
        #1;
        chk("t5_hold_tgt", predicted_target_IF, 32'h300);
        chk("t5_hold_bcnt", branch_count, 32'd8);
        chk("t5_hold_mcnt", mispredict_count, 32'd6);
        hold = 1'b0;
        reset = 1'b1;
        #1;
        chk("t5_rst_pred", {31'd0, predict_taken_IF}, 32'd0);
        chk("t5_rst_misp", {31'd0, mispredict}, 32'd0);
        chk("t5_rst_bcnt", branch_count, 32'd0);
        chk("t5_rst_mcnt", mispredict_count, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        ex(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
        #1;
        chk("t5_post_rst_pred", {31'd0, predict_taken_IF}, 32'd0);

        // 6: branch counter wrap and recovery_pc wrap
        @(negedge clk);
        force dut.branch_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.branch_cnt;
        ex(1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0, 1'b0, 32'h0);
        #1;
        chk("t6_preload", branch_count, 32'hFFFF_FFFF);
        chk("t6_misp", {31'd0, mispredict}, 32'd0);
        chk("t6_rpc_wrap", recovery_pc, 32'h0);
        next_idle();
        chk("t6_bcnt_wrap", branch_count, 32'd0);
        chk("t6_mcnt", mispredict_count, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
